prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// Program sequencer: Start-pulse driven program selection, PC update with
// absolute/relative/base-relative branches, call/return stack and sticky error.
module prog_sequencer #(
  parameter int unsigned         A         = 10,
  parameter int unsigned         NPROG     = 3,
  parameter int unsigned         DEPTH     = 4,
  parameter int unsigned         TW        = 8,
  parameter logic [NPROG*A-1:0]  PROG_BASE = {10'd500, 10'd200, 10'd0}
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Start,
  input  logic                         Stall,
  input  logic                         BrEn,
  input  logic [1:0]                   BrMode,
  input  logic                         Call,
  input  logic                         Cond,
  input  logic [TW-1:0]                Target,
  output logic [A-1:0]                 ProgCtr,
  output logic [$clog2(NPROG+2)-1:0]   ProgIdx,
  output logic                         Running,
  output logic                         Done,
  output logic [$clog2(DEPTH+1)-1:0]   StkCount,
  output logic                         StkErr
);

  localparam int unsigned IW = $clog2(NPROG + 2);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(DEPTH);

  logic          start_r_q, start_r_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [IW-1:0] prog_idx_q, prog_idx_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic [CW-1:0] stk_cnt_q, stk_cnt_d;
  logic          stk_err_q, stk_err_d;
  logic [A-1:0]  stk_q [DEPTH];
  logic [A-1:0]  stk_d [DEPTH];

  logic          rise_c, fall_c, taken_c;
  logic [A-1:0]  base_c, pc_inc_c, br_pc_c;

  // Start address of the currently selected program (0 when out of range)
  always_comb begin
    base_c = '0;
    for (int unsigned k = 1; k <= NPROG; k++) begin
      if (prog_idx_q == IW'(k)) base_c = PROG_BASE[(k-1)*A +: A];
    end
  end

  always_comb begin
    rise_c   = Start & ~start_r_q;
    fall_c   = ~Start & start_r_q;
    taken_c  = running_q & ~Stall & BrEn & (Cond | (BrMode == 2'b11));
    pc_inc_c = pc_q + A'(1);
    unique case (BrMode)
      2'b00:   br_pc_c = A'(Target);
      2'b01:   br_pc_c = pc_q + A'($signed(Target));
      2'b10:   br_pc_c = base_c + A'(Target);
      default: br_pc_c = pc_inc_c;
    endcase
  end

  // Next-state: program load > stall > branch/return > increment
  always_comb begin
    start_r_d  = Start;
    pc_d       = pc_q;
    prog_idx_d = prog_idx_q;
    running_d  = running_q;
    done_d     = done_q;
    stk_cnt_d  = stk_cnt_q;
    stk_err_d  = stk_err_q;
    stk_d      = stk_q;

    if (rise_c && prog_idx_q != IW'(NPROG + 1)) prog_idx_d = prog_idx_q + IW'(1);

    if (fall_c && prog_idx_q >= IW'(1) && prog_idx_q <= IW'(NPROG)) begin
      pc_d      = base_c;
      running_d = 1'b1;
      stk_cnt_d = '0;
      stk_err_d = 1'b0;
    end else if (fall_c && prog_idx_q == IW'(NPROG + 1)) begin
      done_d    = 1'b1;
      running_d = 1'b0;
    end else if (running_q && !Stall) begin
      if (taken_c && BrMode == 2'b11) begin
        if (stk_cnt_q == '0) begin
          stk_err_d = 1'b1;
          pc_d      = pc_inc_c;
        end else begin
          pc_d      = stk_q[SW'(stk_cnt_q - CW'(1))];
          stk_cnt_d = stk_cnt_q - CW'(1);
        end
      end else if (taken_c) begin
        pc_d = br_pc_c;
        if (Call) begin
          if (stk_cnt_q == CW'(DEPTH)) begin
            stk_err_d = 1'b1;
          end else begin
            stk_d[SW'(stk_cnt_q)] = pc_inc_c;
            stk_cnt_d             = stk_cnt_q + CW'(1);
          end
        end
      end else begin
        pc_d = pc_inc_c;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start_r_q  <= 1'b0;
      pc_q       <= '0;
      prog_idx_q <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      stk_cnt_q  <= '0;
      stk_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      start_r_q  <= start_r_d;
      pc_q       <= pc_d;
      prog_idx_q <= prog_idx_d;
      running_q  <= running_d;
      done_q     <= done_d;
      stk_cnt_q  <= stk_cnt_d;
      stk_err_q  <= stk_err_d;
      stk_q      <= stk_d;
    end
  end

  assign ProgCtr  = pc_q;
  assign ProgIdx  = prog_idx_q;
  assign Running  = running_q;
  assign Done     = done_q;
  assign StkCount = stk_cnt_q;
  assign StkErr   = stk_err_q;

endmodule
